// File: rtl/pipe_stage_chain.sv
// Stallable, flushable chain of pipeline register stages with valid/ready
// handshakes at both ends, per-stage hold and kill, occupancy and flush tally.
module pipe_stage_chain #(
    parameter int STAGES = 4,
    parameter int DATA_W = 16,
    parameter int CTRL_W = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [CTRL_W-1:0]                in_ctrl,
    input  logic [DATA_W-1:0]                in_data,
    input  logic [STAGES-1:0]                stall_req,
    input  logic [STAGES-1:0]                flush_mask,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [CTRL_W-1:0]                out_ctrl,
    output logic [DATA_W-1:0]                out_data,
    output logic [STAGES-1:0]                stage_valid,
    output logic [$clog2(STAGES+1)-1:0]      occupancy,
    output logic [7:0]                       flush_count
);

    localparam int OCC_W = $clog2(STAGES + 1);
    localparam int LAST  = STAGES - 1;

    logic [STAGES-1:0] r_valid;
    logic [CTRL_W-1:0] r_ctrl [STAGES];
    logic [DATA_W-1:0] r_data [STAGES];
    logic [OCC_W-1:0]  r_occ;
    logic [7:0]        r_fcnt;

    logic [STAGES-1:0] w_eff;
    logic [STAGES-1:0] w_hold;
    logic [STAGES-1:0] w_load;
    logic [STAGES-1:0] w_valid_nxt;
    logic              w_in_ready;
    logic [8:0]        w_fsum;

    function automatic logic [OCC_W-1:0] popcnt(input logic [STAGES-1:0] v);
        logic [OCC_W-1:0] c;
        c = '0;
        for (int unsigned k = 0; k < STAGES; k++)
            c = c + OCC_W'(v[k]);
        return c;
    endfunction

    always_comb begin
        logic h;
        w_eff  = r_valid & ~flush_mask;
        w_hold = '0;
        // Hold ripples upstream from the output; a local carries it to avoid a self-referencing vector.
        h = stall_req[LAST] | (w_eff[LAST] & ~out_ready);
        w_hold[LAST] = h;
        for (int unsigned k = 0; k < STAGES - 1; k++) begin
            h = stall_req[STAGES-2-k] | (w_eff[STAGES-2-k] & h);
            w_hold[STAGES-2-k] = h;
        end

        w_in_ready = ~w_hold[0] & ~flush_mask[0] & reset;
        w_load     = '0;
        w_load[0]  = in_valid & w_in_ready;
        for (int unsigned i = 1; i < STAGES; i++)
            w_load[i] = w_eff[i-1] & ~w_hold[i-1];

        w_valid_nxt = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            if (flush_mask[i])
                w_valid_nxt[i] = w_load[i];
            else if (w_hold[i])
                w_valid_nxt[i] = r_valid[i];
            else
                w_valid_nxt[i] = w_load[i];
        end

        w_fsum = {1'b0, r_fcnt} + 9'(popcnt(r_valid & flush_mask));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid <= '0;
            r_occ   <= '0;
            r_fcnt  <= '0;
            for (int unsigned i = 0; i < STAGES; i++) begin
                r_ctrl[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            r_valid <= w_valid_nxt;
            r_occ   <= popcnt(w_valid_nxt);
            r_fcnt  <= w_fsum[8] ? 8'hFF : w_fsum[7:0];
            if (w_load[0]) begin
                r_ctrl[0] <= in_ctrl;
                r_data[0] <= in_data;
            end
            for (int unsigned i = 1; i < STAGES; i++) begin
                if (w_load[i]) begin
                    r_ctrl[i] <= r_ctrl[i-1];
                    r_data[i] <= r_data[i-1];
                end
            end
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = w_eff[LAST] & ~stall_req[LAST] & reset;
    assign out_ctrl    = r_ctrl[LAST];
    assign out_data    = r_data[LAST];
    assign stage_valid = r_valid;
    assign occupancy   = r_occ;
    assign flush_count = r_fcnt;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Scoreboard bench for pipe_stage_chain: accepted inputs are queued, outputs
// are popped and compared; flush/reset tests retire killed entries explicitly.
module tb_pipe_stage_chain;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_ctrl;
    logic [15:0] in_data;
    logic [3:0]  stall_req;
    logic [3:0]  flush_mask;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_ctrl;
    logic [15:0] out_data;
    logic [3:0]  stage_valid;
    logic [2:0]  occupancy;
    logic [7:0]  flush_count;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_n   = 0;
    int first_in  = -1;
    int first_out = -1;
    int last_out  = -1;
    int exp_fc;
    logic [31:0] sb_q[$];

    pipe_stage_chain #(.STAGES(4), .DATA_W(16), .CTRL_W(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .stall_req(stall_req), .flush_mask(flush_mask),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .stage_valid(stage_valid), .occupancy(occupancy), .flush_count(flush_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    // Scoreboard monitor, sampled mid-cycle with inputs stable.
    always @(negedge clk) begin
        if (in_valid && in_ready) begin
            sb_q.push_back({in_ctrl, in_data});
            if (first_in < 0) first_in = cyc_n;
        end
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_nonempty", 32'(sb_q.size()), 32'd1);
            end else begin
                check("out_entry", {out_ctrl, out_data}, sb_q.pop_front());
                if (first_out < 0) first_out = cyc_n;
                last_out = cyc_n;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [15:0] base, input int n);
        out_ready = 1'b0;
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_data  = base + 16'(k);
            in_ctrl  = ~(base + 16'(k));
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        out_ready = 1'b1;
        repeat (n) tick();
        check("drain_empty", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
        stall_req = '0; flush_mask = '0; out_ready = 1'b1;
        tick(); tick();
        check("rst_stage_valid", 32'(stage_valid), 32'd0);
        check("rst_occupancy",   32'(occupancy),   32'd0);
        check("rst_flush_count", 32'(flush_count), 32'd0);
        check("rst_in_ready",    32'(in_ready),    32'd0);
        check("rst_out_valid",   32'(out_valid),   32'd0);
        reset = 1'b1;
        #1 check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Stream 1..6 back to back
        first_in = -1; first_out = -1; last_out = -1;
        for (int i = 1; i <= 6; i++) begin
            in_valid = 1'b1; in_data = 16'(i); in_ctrl = 16'h5A00 + 16'(i);
            #1 check("stream_in_ready", 32'(in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        drain(10);
        check("stream_latency", 32'(first_out - first_in), 32'd4);
        check("stream_span",    32'(last_out - first_out), 32'd5);

        // Stall on stage 1 with a full pipe
        fill(16'h00A1, 4);
        check("stall_full_occ", 32'(occupancy),   32'd4);
        check("stall_full_sv",  32'(stage_valid), 32'b1111);
        out_ready = 1'b1; stall_req = 4'b0010;
        #1 check("stall_in_ready0", 32'(in_ready), 32'd0);
        tick();
        check("stall_occ1", 32'(occupancy),   32'd3);
        check("stall_sv1",  32'(stage_valid), 32'b1011);
        check("stall_in_ready1", 32'(in_ready), 32'd0);
        tick();
        stall_req = 4'b0000;
        check("stall_occ2", 32'(occupancy),   32'd2);
        check("stall_sv2",  32'(stage_valid), 32'b0011);
        drain(6);

        // Backpressure with continuous input, then simultaneous in/out at full
        out_ready = 1'b0;
        for (int n = 0; n < 6; n++) begin
            in_valid = 1'b1; in_data = 16'h00C0 + 16'(n); in_ctrl = 16'h3C00 + 16'(n);
            tick();
        end
        #1;
        check("bp_in_ready", 32'(in_ready),  32'd0);
        check("bp_occ",      32'(occupancy), 32'd4);
        out_ready = 1'b1; in_data = 16'h00D0; in_ctrl = 16'h3CD0;
        #1 check("full_swap_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("full_swap_occ", 32'(occupancy), 32'd4);
        drain(8);

        // Flush the two youngest stages under backpressure
        fill(16'h00B1, 4);
        flush_mask = 4'b0011; in_valid = 1'b1; in_data = 16'h00EE; in_ctrl = 16'h00EE;
        #1;
        check("flush_in_ready", 32'(in_ready),    32'd0);
        check("flush_fc_before", 32'(flush_count), 32'd0);
        tick();
        flush_mask = '0; in_valid = 1'b0;
        void'(sb_q.pop_back()); void'(sb_q.pop_back());
        check("flush_occ", 32'(occupancy),   32'd2);
        check("flush_sv",  32'(stage_valid), 32'b1100);
        check("flush_fc",  32'(flush_count), 32'd2);
        drain(6);

        // Stall and flush on the same stage: the flush wins
        fill(16'h00E1, 4);
        stall_req = 4'b0100; flush_mask = 4'b0100;
        tick();
        stall_req = '0; flush_mask = '0;
        sb_q.delete(1);
        check("sf_sv",  32'(stage_valid), 32'b1011);
        check("sf_occ", 32'(occupancy),   32'd3);
        check("sf_fc",  32'(flush_count), 32'd3);
        drain(6);

        // Repeated full flushes drive the counter into saturation
        exp_fc = 3;
        for (int it = 0; it < 64; it++) begin
            fill(16'h0F00 + 16'(it * 4), 4);
            flush_mask = 4'b1111;
            tick();
            flush_mask = '0;
            repeat (4) void'(sb_q.pop_back());
            exp_fc = (exp_fc + 4 > 255) ? 255 : exp_fc + 4;
            check("fc_step", 32'(flush_count), 32'(exp_fc));
        end
        check("fc_saturated", 32'(flush_count), 32'd255);
        check("sat_occ", 32'(occupancy), 32'd0);

        // Reset with entries in flight
        fill(16'h0031, 3);
        check("mid_occ", 32'(occupancy), 32'd3);
        reset = 1'b0; out_ready = 1'b1;
        #1;
        check("mid_rst_in_ready",  32'(in_ready),  32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        tick();
        sb_q.delete();
        check("mid_rst_sv",        32'(stage_valid), 32'd0);
        check("mid_rst_occ",       32'(occupancy),   32'd0);
        check("mid_rst_fc",        32'(flush_count), 32'd0);
        check("mid_rst_out_valid2", 32'(out_valid),  32'd0);
        check("mid_rst_in_ready2", 32'(in_ready),    32'd0);
        reset = 1'b1;
        #1 check("mid_rel_in_ready", 32'(in_ready), 32'd1);
        tick(); tick();
        check("mid_rel_occ", 32'(occupancy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
